// File: rtl/spi_flash_reader_if.sv
// Handshake and SPI pin bundle for spi_flash_reader.
// The slave side is the sequencer and the master side is its user.
interface spi_flash_reader_if #(
  parameter int LEN_BITS = 8
);
  logic                start;
  logic [23:0]         addr;
  logic [LEN_BITS-1:0] len;
  logic                busy;
  logic                done;
  logic [7:0]          data;
  logic                data_valid;
  logic                spi_cs;
  logic                spi_sclk;
  logic                spi_mosi;
  logic                spi_miso;

  modport slave (
    input  start, addr, len, spi_miso,
    output busy, done, data, data_valid,
    output spi_cs, spi_sclk, spi_mosi
  );

  modport master (
    output start, addr, len, spi_miso,
    input  busy, done, data, data_valid,
    input  spi_cs, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI flash READ sequencer: command plus 24-bit address, then len bytes.
// Two clk per SPI bit; every output is registered.
module spi_flash_reader #(
  parameter logic [7:0] SPI_CMD  = 8'h03,
  parameter int         LEN_BITS = 8
) (
  input logic clk,
  input logic reset,
  spi_flash_reader_if.slave bus
);
  localparam int CW = LEN_BITS + 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_FINISH
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [30:0]         r_shift;
  logic [LEN_BITS-1:0] r_len;
  logic [6:0]          r_rx;
  logic [7:0]          r_data;
  logic                r_dv;
  logic                r_done;
  logic                r_busy;
  logic                r_cs;
  logic                r_sclk;
  logic                r_mosi;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [30:0]         w_shift_nxt;
  logic [LEN_BITS-1:0] w_len_nxt;
  logic [6:0]          w_rx_nxt;
  logic [7:0]          w_data_nxt;
  logic                w_dv_nxt;
  logic                w_done_nxt;
  logic                w_busy_nxt;
  logic                w_cs_nxt;
  logic                w_sclk_nxt;
  logic                w_mosi_nxt;
  logic [CW-1:0]       w_end;

  // r_cnt counts edges since acceptance; the last falling edge is 64+16*len
  assign w_end = CW'({r_len, 4'h0}) + CW'(63);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_len_nxt   = r_len;
    w_rx_nxt    = r_rx;
    w_data_nxt  = r_data;
    w_dv_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_cs_nxt    = r_cs;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    unique case (r_state)
      S_IDLE, S_FINISH: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_cs_nxt    = 1'b0;
        w_sclk_nxt  = 1'b0;
        w_mosi_nxt  = 1'b0;
        if (bus.start) begin
          w_len_nxt   = bus.len;
          w_shift_nxt = {SPI_CMD[6:0], bus.addr};
          w_cnt_nxt   = '0;
          if (bus.len == '0) begin
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_PRE;
            w_busy_nxt  = 1'b1;
            w_cs_nxt    = 1'b1;
            w_mosi_nxt  = SPI_CMD[7];
          end
        end
      end
      S_PRE, S_DATA: begin
        w_cnt_nxt  = r_cnt + CW'(1);
        w_sclk_nxt = ~r_sclk;
        if (!r_sclk) begin
          if (r_state == S_DATA) begin
            w_rx_nxt = {r_rx[5:0], bus.spi_miso};
            if (r_cnt[3:0] == 4'd14) begin
              w_data_nxt = {r_rx, bus.spi_miso};
              w_dv_nxt   = 1'b1;
            end
          end
        end else begin
          w_shift_nxt = {r_shift[29:0], 1'b0};
          w_mosi_nxt  = r_shift[30];
          if (r_state == S_PRE && r_cnt == CW'(63)) begin
            w_state_nxt = S_DATA;
            w_mosi_nxt  = 1'b0;
          end
          if (r_state == S_DATA && r_cnt == w_end) begin
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_cs_nxt    = 1'b0;
            w_sclk_nxt  = 1'b0;
            w_mosi_nxt  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_len   <= '0;
      r_rx    <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_len   <= w_len_nxt;
      r_rx    <= w_rx_nxt;
      r_data  <= w_data_nxt;
      r_dv    <= w_dv_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_cs    <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.data       = r_data;
  assign bus.data_valid = r_dv;
  assign bus.spi_cs     = r_cs;
  assign bus.spi_sclk   = r_sclk;
  assign bus.spi_mosi   = r_mosi;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural flash plus timing model.
// Directed cases followed by randomized back-to-back transfers.
module tb_spi_flash_reader;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad = 0;

  spi_flash_reader_if #(.LEN_BITS(8)) ifc ();

  spi_flash_reader #(
    .SPI_CMD (8'h03),
    .LEN_BITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  logic [7:0]  fmem [256];
  int          f_rise = 0;
  logic        f_prev = 1'b0;
  logic [31:0] f_sh = '0;
  logic [31:0] f_word = '0;

  // flash: shifts in cmd/addr on sclk rises, streams bytes from its address
  always @(negedge clk) begin
    int d;
    logic [7:0] idx;
    if (!ifc.spi_cs) begin
      f_rise = 0;
      f_sh   = '0;
    end else if (ifc.spi_sclk && !f_prev) begin
      if (f_rise < 32) f_sh = {f_sh[30:0], ifc.spi_mosi};
      f_rise++;
      if (f_rise == 32) f_word = f_sh;
    end
    f_prev = ifc.spi_sclk;
    if (ifc.spi_cs && f_rise >= 32) begin
      d   = f_rise - 32;
      idx = f_word[7:0] + 8'(d / 8);
      ifc.spi_miso = fmem[idx][7 - (d % 8)];
    end else begin
      ifc.spi_miso = 1'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [23:0] a, input logic [7:0] n,
                      input bit hold);
    int t, lim, cs_cnt, rises, shape_bad, dv_n, done_t, span;
    logic prev;
    logic [7:0] idx;
    span = (n == 0) ? 0 : 64 + 16 * int'(n);
    lim = span + 8;
    cs_cnt = 0; rises = 0; shape_bad = 0; dv_n = 0; done_t = -1;
    prev = 1'b0;
    ifc.addr  = a;
    ifc.len   = n;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) ifc.start = 1'b0;
    ifc.addr = 24'($urandom);
    ifc.len  = 8'($urandom);
    for (t = 0; t <= lim; t++) begin
      @(negedge clk);
      cs_cnt += int'(ifc.spi_cs);
      if (ifc.spi_sclk && !prev) rises++;
      prev = ifc.spi_sclk;
      if (ifc.spi_cs !== (t < span)) shape_bad++;
      if (ifc.busy !== (t < span)) shape_bad++;
      if (!ifc.spi_cs && ifc.spi_sclk) shape_bad++;
      if (ifc.data_valid) begin
        idx = a[7:0] + 8'(dv_n);
        chk("dv_time", t, 79 + 16 * dv_n);
        chk("dv_data", ifc.data, fmem[idx]);
        dv_n++;
      end
      if (ifc.done) begin
        done_t = t;
        break;
      end
    end
    chk("done_time", done_t, span);
    chk("cs_cycles", cs_cnt, span);
    chk("sclk_rises", rises, (n == 0) ? 0 : 32 + 8 * int'(n));
    chk("cs_busy_shape", shape_bad, 0);
    chk("dv_count", dv_n, n);
    if (n != 0) begin
      idx = a[7:0] + n - 8'd1;
      chk("mosi_word", f_word, {8'h03, a});
      chk("data_hold", ifc.data, fmem[idx]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, ev;
    bit hold;
    for (int i = 0; i < 256; i++) fmem[i] = 8'($urandom);
    reset = 1'b1;
    ifc.start = 1'b0;
    ifc.addr  = '0;
    ifc.len   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.busy || ifc.done || ifc.data_valid || ifc.spi_cs ||
          ifc.spi_sclk || ifc.spi_mosi) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("reset_data", ifc.data, 8'h00);

    fmem[8'h20] = 8'hA5;
    xfer(24'h000120, 8'd1, 1'b0);

    fmem[8'h40] = 8'h12;
    fmem[8'h41] = 8'h34;
    fmem[8'h42] = 8'h56;
    repeat (3) @(negedge clk);
    xfer(24'h5A0040, 8'd3, 1'b0);
    @(negedge clk);
    chk("no_extra_dv", ifc.data_valid, 1'b0);

    xfer(24'($urandom), 8'd0, 1'b0);

    xfer(24'($urandom), 8'd2, 1'b1);
    xfer(24'($urandom), 8'd2, 1'b0);

    ifc.addr  = 24'($urandom);
    ifc.len   = 8'd4;
    ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    ev = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ifc.data_valid || ifc.done) ev++;
      if (t == 39) reset = 1'b1;
    end
    @(negedge clk);
    chk("rst_cs", ifc.spi_cs, 1'b0);
    chk("rst_sclk", ifc.spi_sclk, 1'b0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_data", ifc.data, 8'h00);
    chk("rst_no_pulse", ev + int'(ifc.done) + int'(ifc.data_valid), 0);
    reset = 1'b0;
    xfer(24'($urandom), 8'd2, 1'b0);

    for (int i = 0; i < 10; i++) begin
      hold = (i < 9) && ($urandom_range(0, 1) == 1);
      xfer(24'($urandom), 8'($urandom_range(0, 5)), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
